gray_step_checker: RTL and testbench

//  Sits directly downstream of the 3-bit Gray counter stage and consumes its

---
 rtl/gray_step_checker.sv | 123 ++++++++++++
 tb/tb_gray_step_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_checker.sv
// Follows the upstream Gray counter: decodes each sample, classifies every transition,
// counts laps and latches the first fault until Reset.
//
// state  | meaning
// S_INIT | capture the first sample as the reference, no classification
// S_TRACK| classify each transition as hold, +1 step or fault
// S_FAULT| first fault latched; decode keeps tracking, counters frozen
module gray_step_checker #(
  parameter int W     = 3,
  parameter int LAP_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [W-1:0]     GrayIn,
  input  logic             OvfIn,
  output logic [W-1:0]     Bin,
  output logic             Valid,
  output logic             Step,
  output logic             Hold,
  output logic [LAP_W-1:0] LapCnt,
  output logic             LapSat,
  output logic             Err,
  output logic [1:0]       ErrCode
);

  typedef enum logic [1:0] {S_INIT, S_TRACK, S_FAULT} state_t;

  localparam logic [W-1:0]     CODE_ONE = W'(1);
  localparam logic [W-1:0]     CODE_MAX = '1;
  localparam logic [LAP_W-1:0] LAP_ONE  = LAP_W'(1);
  localparam logic [LAP_W-1:0] LAP_MAX  = '1;

  state_t       state, state_nx;
  logic [W-1:0] prev_g, prev_b;
  logic         prev_ovf;
  logic [W-1:0] bin_dec, delta, g_diff;
  logic         wrap, rise, fall;
  logic         multi_bit, bad_single, ovf_bad;
  logic         step_nx, hold_nx, lap_inc, fault;
  logic [1:0]   code_nx;

  // Binary bit i is the XOR of all Gray bits at or above i.
  for (genvar i = 0; i < W; i++) begin : g_decode
    assign bin_dec[i] = ^GrayIn[W-1:i];
  end

  assign delta      = bin_dec - prev_b;
  assign g_diff     = GrayIn ^ prev_g;
  assign wrap       = (prev_b == CODE_MAX) && (bin_dec == '0);
  assign rise       = OvfIn && !prev_ovf;
  assign fall       = !OvfIn && prev_ovf;
  assign multi_bit  = (g_diff & (g_diff - CODE_ONE)) != '0;
  assign bad_single = (g_diff != '0) && (delta != CODE_ONE);
  assign ovf_bad    = (rise && !wrap) || fall || (wrap && !OvfIn);

  always_comb begin
    state_nx = state;
    step_nx  = 1'b0;
    hold_nx  = 1'b0;
    lap_inc  = 1'b0;
    fault    = 1'b0;
    code_nx  = 2'b00;
    case (state)
      S_INIT:  state_nx = S_TRACK;
      S_TRACK: begin
        if (multi_bit) begin
          fault   = 1'b1;
          code_nx = 2'b01;
        end else if (bad_single) begin
          fault   = 1'b1;
          code_nx = 2'b10;
        end else if (ovf_bad) begin
          fault   = 1'b1;
          code_nx = 2'b11;
        end else if (g_diff == '0) begin
          hold_nx = 1'b1;
        end else begin
          step_nx = 1'b1;
          lap_inc = wrap;
        end
        if (fault) state_nx = S_FAULT;
      end
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_INIT;
      prev_g   <= '0;
      prev_b   <= '0;
      prev_ovf <= 1'b0;
      Bin      <= '0;
      Valid    <= 1'b0;
      Step     <= 1'b0;
      Hold     <= 1'b0;
      LapCnt   <= '0;
      LapSat   <= 1'b0;
      Err      <= 1'b0;
      ErrCode  <= 2'b00;
    end else begin
      state    <= state_nx;
      prev_g   <= GrayIn;
      prev_b   <= bin_dec;
      prev_ovf <= OvfIn;
      Bin      <= bin_dec;
      Valid    <= 1'b1;
      Step     <= step_nx;
      Hold     <= hold_nx;
      if (fault) begin
        Err     <= 1'b1;
        ErrCode <= code_nx;
      end
      // A wrap at full count pins the counter and flags saturation instead.
      if (lap_inc) begin
        if (LapCnt == LAP_MAX) LapSat <= 1'b1;
        else                   LapCnt <= LapCnt + LAP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_gray_step_checker.sv
// Directed bench for gray_step_checker: two instances (default lap width and a 2-bit lap
// counter) checked each cycle against an arithmetic model, plus hand-computed spot values.
module tb_gray_step_checker;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] GrayIn = 3'd0;
  logic       OvfIn = 1'b0;

  logic [2:0] a_bin, b_bin;
  logic       a_valid, a_step, a_hold, a_sat, a_err;
  logic       b_valid, b_step, b_hold, b_sat, b_err;
  logic [7:0] a_lap;
  logic [1:0] b_lap, a_code, b_code;

  gray_step_checker dut_a (
    .Clk(Clk), .Reset(Reset), .GrayIn(GrayIn), .OvfIn(OvfIn),
    .Bin(a_bin), .Valid(a_valid), .Step(a_step), .Hold(a_hold),
    .LapCnt(a_lap), .LapSat(a_sat), .Err(a_err), .ErrCode(a_code)
  );

  gray_step_checker #(.W(3), .LAP_W(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .GrayIn(GrayIn), .OvfIn(OvfIn),
    .Bin(b_bin), .Valid(b_valid), .Step(b_step), .Hold(b_hold),
    .LapCnt(b_lap), .LapSat(b_sat), .Err(b_err), .ErrCode(b_code)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  typedef struct {
    int mode;  // 0 capture pending, 1 tracking, 2 faulted
    int pg, pb;
    bit po;
    int bin;
    bit valid, step, hold, sat, err;
    int lap, code;
  } mdl_t;

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};

  function automatic logic [2:0] gray(int n);
    logic [2:0] v;
    v = 3'(n);
    return v ^ (v >> 1);
  endfunction

  function automatic mdl_t step_model(mdl_t s, int g, bit ovf, bit rst, int lap_max);
    mdl_t r;
    int b, flips, d, code;
    bit wrap;
    if (rst) begin
      r = '{default: 0};
      return r;
    end
    b = 0;
    for (int n = 0; n < 8; n++) if (int'(gray(n)) == g) b = n;
    r = s;
    r.step = 0;
    r.hold = 0;
    r.bin = b;
    r.valid = 1;
    if (s.mode == 0) begin
      r.mode = 1;
    end else if (s.mode == 1) begin
      flips = $countones(g ^ s.pg);
      d = (b - s.pb + 8) % 8;
      wrap = (s.pb == 7) && (b == 0);
      code = 0;
      if (flips > 1) code = 1;
      else if (flips == 1 && d != 1) code = 2;
      else if ((ovf && !s.po && !wrap) || (!ovf && s.po) || (wrap && !ovf)) code = 3;
      if (code != 0) begin
        r.err = 1;
        r.code = code;
        r.mode = 2;
      end else if (flips == 0) begin
        r.hold = 1;
      end else begin
        r.step = 1;
        if (wrap) begin
          if (s.lap == lap_max) r.sat = 1;
          else r.lap = s.lap + 1;
        end
      end
    end
    r.pg = g;
    r.pb = b;
    r.po = ovf;
    return r;
  endfunction

  function automatic logic [17:0] pack_model(mdl_t m);
    return {3'(m.bin), m.valid, m.step, m.hold, 8'(m.lap), m.sat, m.err, 2'(m.code)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) begin
    ma = step_model(ma, int'(GrayIn), OvfIn, Reset, 255);
    mb = step_model(mb, int'(GrayIn), OvfIn, Reset, 3);
  end

  always @(negedge Clk) begin
    if (started) begin
      check("dut_a outputs", {14'd0, a_bin, a_valid, a_step, a_hold, a_lap, a_sat, a_err, a_code},
            {14'd0, pack_model(ma)});
      check("dut_b outputs", {14'd0, b_bin, b_valid, b_step, b_hold, 6'd0, b_lap, b_sat, b_err, b_code},
            {14'd0, pack_model(mb)});
    end
  end

  task automatic sample(int g, bit ovf);
    GrayIn = gray(0) ^ 3'(g);
    OvfIn = ovf;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  int step_cnt;

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    do_reset();
    started = 1'b1;
    check("reset all zero", {a_bin, a_valid, a_step, a_hold, a_lap, a_sat, a_err, a_code}, 32'd0);

    // Full lap 0..7 then wrap to 0 with the overflow flag rising at the wrap.
    step_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      sample(gray(n), 1'b0);
      if (a_step) step_cnt++;
      check("lap1 bin", a_bin, n);
    end
    sample(0, 1'b1);
    if (a_step) step_cnt++;
    check("lap1 step count", step_cnt, 8);
    check("lap1 lapcnt", a_lap, 1);
    check("lap1 bin wrap", a_bin, 0);
    check("lap1 err", a_err, 0);

    // Hold detection: 011 held for three samples after a step.
    sample(3'b001, 1'b1);
    sample(3'b011, 1'b1);
    check("hold step", a_step, 1);
    sample(3'b011, 1'b1);
    check("hold pulse1", {a_hold, a_step}, 2'b10);
    sample(3'b011, 1'b1);
    check("hold pulse2", {a_hold, a_step}, 2'b10);
    sample(3'b010, 1'b1);
    check("hold end", {a_hold, a_step}, 2'b01);

    // Multi-bit jump 001 -> 010, then tracking continues under the fault.
    do_reset();
    sample(3'b000, 1'b0);
    sample(3'b001, 1'b0);
    sample(3'b010, 1'b0);
    check("multibit err", {a_err, a_code}, 3'b101);
    sample(3'b011, 1'b0);
    check("fault bin 011", {a_bin, a_step}, {3'd2, 1'b0});
    sample(3'b010, 1'b0);
    check("fault bin 010", {a_bin, a_step}, {3'd3, 1'b0});
    check("fault lap frozen", a_lap, 0);

    // Backward single-bit step 011 -> 001.
    do_reset();
    sample(3'b000, 1'b0);
    sample(3'b001, 1'b0);
    sample(3'b011, 1'b0);
    sample(3'b001, 1'b0);
    check("backward code", {a_err, a_code}, 3'b110);

    // Single-bit skip 001 -> 101 (1 -> 6).
    do_reset();
    sample(3'b000, 1'b0);
    sample(3'b001, 1'b0);
    sample(3'b101, 1'b0);
    check("skip code", {a_err, a_code}, 3'b110);
    check("skip bin", a_bin, 6);

    // Overflow rising on a legal non-wrap step.
    do_reset();
    sample(3'b000, 1'b0);
    sample(3'b001, 1'b0);
    sample(3'b011, 1'b0);
    sample(3'b010, 1'b0);
    sample(3'b110, 1'b1);
    check("ovf rise code", {a_err, a_code, a_step}, 4'b1110);

    // Wrap without the overflow flag.
    do_reset();
    for (int n = 0; n < 8; n++) sample(gray(n), 1'b0);
    sample(3'b000, 1'b0);
    check("wrap no ovf code", {a_err, a_code}, 3'b111);
    check("wrap no ovf lap", a_lap, 0);

    // Four laps: 2-bit counter saturates at 3.
    do_reset();
    sample(3'b000, 1'b0);
    for (int lap = 1; lap <= 4; lap++) begin
      for (int n = 1; n < 8; n++) sample(gray(n), lap > 1);
      sample(3'b000, 1'b1);
    end
    check("sat lap b", {b_lap, b_sat}, 3'b111);
    check("sat lap a", {a_lap, a_sat}, {8'd4, 1'b0});
    check("sat no err", {a_err, b_err}, 2'b00);

    // Reset in the middle of a lap, then a fresh capture.
    sample(3'b001, 1'b1);
    sample(3'b011, 1'b1);
    do_reset();
    check("midlap reset a", {a_bin, a_valid, a_step, a_hold, a_lap, a_sat, a_err, a_code}, 32'd0);
    check("midlap reset b", {b_bin, b_valid, b_step, b_hold, b_lap, b_sat, b_err, b_code}, 32'd0);
    sample(3'b010, 1'b1);
    check("recapture", {a_valid, a_step, a_bin, b_lap}, {1'b1, 1'b0, 3'd3, 2'd0});
    sample(3'b110, 1'b1);
    check("post recapture step", {a_step, a_err}, 2'b10);

    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
